// File: rtl/axis_downsizer.sv
// rtl/axis_downsizer.sv - AXI4-Stream width down-converter, LSB lane first, trims empty tail lanes on tlast
// Optional statistics counters: define AXIS_DOWNSIZER_STATS_EN.
module axis_downsizer #(
    parameter int S_WIDTH = 64,
    parameter int M_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 sys_arstn,
    input  logic [S_WIDTH-1:0]   s_tdata,
    input  logic [S_WIDTH/8-1:0] s_tkeep,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [M_WIDTH-1:0]   m_tdata,
    output logic [M_WIDTH/8-1:0] m_tkeep,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready
`ifdef AXIS_DOWNSIZER_STATS_EN
    ,
    output logic [31:0]          o_pkt_cnt,
    output logic [31:0]          o_beat_cnt,
    output logic [15:0]          o_trim_cnt
`endif
);

    localparam int R      = S_WIDTH / M_WIDTH;
    localparam int LANE_W = $clog2(R);
    localparam int SK     = S_WIDTH / 8;
    localparam int MK     = M_WIDTH / 8;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]         state;
    logic [S_WIDTH-1:0] held_data;
    logic [SK-1:0]      held_keep;
    logic               held_last;
    logic [LANE_W-1:0]  lane;
    logic [LANE_W-1:0]  last_lane;
    logic [LANE_W-1:0]  in_last_lane;
    logic               at_last;
    logic               in_hs;
    logic               out_hs;

    // Only the final beat of a packet is trimmed; an all-zero keep still emits lane 0
    // so the packet boundary reaches the DMA.
    function automatic logic [LANE_W-1:0] calc_last_lane(input logic [SK-1:0] keep,
                                                         input logic last);
        logic [LANE_W-1:0] hi;
        hi = '0;
        if (!last) begin
            hi = LANE_W'(R - 1);
        end else begin
            for (int k = 0; k < R; k++) begin
                if (|keep[k*MK +: MK]) begin
                    hi = LANE_W'(k);
                end
            end
        end
        return hi;
    endfunction

    assign in_last_lane = calc_last_lane(s_tkeep, s_tlast);
    assign at_last      = (lane == last_lane);
    assign m_tvalid     = (state == ST_HOLD);
    assign m_tlast      = m_tvalid & held_last & at_last;
    // Reload in the same cycle the final lane leaves, so a stream runs without bubbles.
    assign s_tready     = (state == ST_EMPTY) | ((state == ST_HOLD) & m_tready & at_last);
    assign in_hs        = s_tvalid & s_tready;
    assign out_hs       = m_tvalid & m_tready;

    always_comb begin
        m_tdata = '0;
        m_tkeep = '0;
        for (int k = 0; k < R; k++) begin
            if (lane == LANE_W'(k)) begin
                m_tdata = held_data[k*M_WIDTH +: M_WIDTH];
                m_tkeep = held_keep[k*MK +: MK];
            end
        end
    end

    always_ff @(posedge clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            state     <= ST_EMPTY;
            held_data <= '0;
            held_keep <= '0;
            held_last <= 1'b0;
            lane      <= '0;
            last_lane <= '0;
        end else begin
            if (in_hs) begin
                state     <= ST_HOLD;
                held_data <= s_tdata;
                held_keep <= s_tkeep;
                held_last <= s_tlast;
                lane      <= '0;
                last_lane <= in_last_lane;
            end else if (out_hs) begin
                if (at_last) begin
                    state <= ST_EMPTY;
                end else begin
                    lane <= lane + LANE_W'(1);
                end
            end
        end
    end

`ifdef AXIS_DOWNSIZER_STATS_EN
    always_ff @(posedge clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            o_pkt_cnt  <= '0;
            o_beat_cnt <= '0;
            o_trim_cnt <= '0;
        end else begin
            if (out_hs && m_tlast) begin
                o_pkt_cnt <= o_pkt_cnt + 32'd1;
            end
            if (out_hs) begin
                o_beat_cnt <= o_beat_cnt + 32'd1;
            end
            if (in_hs && s_tlast && (in_last_lane != LANE_W'(R - 1))) begin
                o_trim_cnt <= o_trim_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_downsizer.sv
// tb/tb_axis_downsizer.sv - self-checking bench for axis_downsizer against a queue-based split model
module tb_axis_downsizer;

    logic        clk = 1'b0;
    logic        sys_arstn = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic [1:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b0;
`ifdef AXIS_DOWNSIZER_STATS_EN
    logic [31:0] o_pkt_cnt;
    logic [31:0] o_beat_cnt;
    logic [15:0] o_trim_cnt;
`endif

    axis_downsizer #(.S_WIDTH(64), .M_WIDTH(16)) dut (
        .clk       (clk),
        .sys_arstn (sys_arstn),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready)
`ifdef AXIS_DOWNSIZER_STATS_EN
        ,
        .o_pkt_cnt (o_pkt_cnt),
        .o_beat_cnt(o_beat_cnt),
        .o_trim_cnt(o_trim_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } sbeat_t;

    sbeat_t      src_q[$];
    logic [18:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int bubbles;
    int tlasts;
    int outs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference split: a wide beat becomes R narrow beats, except a last beat stops at
    // its highest lane holding any kept byte (one beat minimum).
    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        sbeat_t b;
        int n;
        logic [63:0] dsh;
        logic [7:0]  ksh;
        b.d = d; b.k = k; b.l = l;
        src_q.push_back(b);
        n = 4;
        if (l) begin
            n = 1;
            for (int i = 0; i < 4; i++)
                if (((k >> (2 * i)) & 8'h03) != 0) n = i + 1;
        end
        for (int i = 0; i < n; i++) begin
            dsh = d >> (16 * i);
            ksh = k >> (2 * i);
            exp_q.push_back({dsh[15:0], ksh[1:0], (l && (i == n - 1))});
        end
    endtask

    task automatic run(input int rdy_pct, input int vld_pct, input int budget, input string tag);
        int cyc;
        bit stall;
        bit started;
        bit hs_in;
        bit hs_out;
        logic [18:0] prev;
        cyc = 0; stall = 0; started = 0; prev = '0;
        bubbles = 0; tlasts = 0; outs = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            m_tready = ($urandom_range(99) < rdy_pct);
            if (src_q.size() > 0 && ($urandom_range(99) < vld_pct)) begin
                s_tvalid = 1'b1;
                s_tdata  = src_q[0].d;
                s_tkeep  = src_q[0].k;
                s_tlast  = src_q[0].l;
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = {$urandom, $urandom};
                s_tkeep  = 8'($urandom);
                s_tlast  = 1'($urandom);
            end
            #1;
            if (stall) begin
                chk({tag, " hold_valid"}, 64'(m_tvalid), 64'd1);
                chk({tag, " hold_stable"}, 64'({m_tdata, m_tkeep, m_tlast}), 64'(prev));
            end
            if (m_tvalid) begin
                started = 1;
                if (exp_q.size() == 0)
                    chk({tag, " extra_beat"}, 64'd1, 64'd0);
                else
                    chk({tag, " beat"}, 64'({m_tdata, m_tkeep, m_tlast}), 64'(exp_q[0]));
            end else if (started && exp_q.size() > 0) begin
                bubbles++;
            end
            stall  = m_tvalid & ~m_tready;
            prev   = {m_tdata, m_tkeep, m_tlast};
            hs_in  = s_tvalid & s_tready;
            hs_out = m_tvalid & m_tready;
            if (hs_out && m_tlast) tlasts++;
            @(posedge clk);
            if (hs_in) void'(src_q.pop_front());
            if (hs_out) begin
                outs++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            cyc++;
        end
        chk({tag, " drained"}, 64'(src_q.size() + exp_q.size()), 64'd0);
        src_q.delete();
        exp_q.delete();
        @(negedge clk);
        s_tvalid = 1'b0;
        m_tready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, " m_tlast"},  64'(m_tlast),  64'd0);
        chk({tag, " m_tdata"},  64'(m_tdata),  64'd0);
        chk({tag, " m_tkeep"},  64'(m_tkeep),  64'd0);
        chk({tag, " s_tready"}, 64'(s_tready), 64'd1);
    endtask

    initial begin
        logic [15:0] w1 [4];
        int plen;
        logic [7:0] lk;
        w1[0] = 16'h1111; w1[1] = 16'h2222; w1[2] = 16'h3333; w1[3] = 16'h4444;

        // Reset state
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs("reset");
        @(negedge clk);
        sys_arstn = 1'b1;

        // Single full last beat with exact cycle-by-cycle latency
        @(negedge clk);
        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 64'h4444_3333_2222_1111; s_tkeep = 8'hFF; s_tlast = 1'b1;
        #1 chk("one_beat s_tready_idle", 64'(s_tready), 64'd1);
        @(negedge clk);
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("one_beat valid", 64'(m_tvalid), 64'd1);
            chk("one_beat data", 64'(m_tdata), 64'(w1[i]));
            chk("one_beat last", 64'(m_tlast), 64'(i == 3));
            chk("one_beat s_tready", 64'(s_tready), 64'(i == 3));
            @(negedge clk);
        end
        #1 chk("one_beat idle_after", 64'(m_tvalid), 64'd0);

        // 160 back-to-back beats with an incrementing lane pattern
        for (int b = 0; b < 160; b++)
            push_beat({16'(4*b+3), 16'(4*b+2), 16'(4*b+1), 16'(4*b)}, 8'hFF, (b == 159));
        run(100, 100, 2000, "b2b");
        chk("b2b bubbles", 64'(bubbles), 64'd0);
        chk("b2b tlast_count", 64'(tlasts), 64'd1);
        chk("b2b out_count", 64'(outs), 64'd640);

        // Trimming of the final beat
        push_beat(64'hDEAD_BEEF_0002_0001, 8'h0F, 1'b1);
        run(100, 100, 100, "trim0f");
        chk("trim0f out_count", 64'(outs), 64'd2);
        push_beat(64'hDEAD_BEEF_0002_0001, 8'h1F, 1'b1);
        run(100, 100, 100, "trim1f");
        chk("trim1f out_count", 64'(outs), 64'd3);
        push_beat(64'hDEAD_BEEF_0002_0001, 8'h00, 1'b1);
        run(100, 100, 100, "trim00");
        chk("trim00 out_count", 64'(outs), 64'd1);

        // Random packets under 50% backpressure and gappy input
        for (int p = 0; p < 100; p++) begin
            plen = $urandom_range(1, 4);
            for (int b = 0; b < plen; b++) begin
                lk = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
                push_beat({$urandom, $urandom}, (b == plen - 1) ? lk : 8'($urandom), (b == plen - 1));
            end
        end
        run(50, 70, 20000, "random");

        // Asynchronous reset while lane 2 of a held word is presented
        @(negedge clk);
        m_tready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 64'hAAAA_BBBB_CCCC_DDDD; s_tkeep = 8'hFF; s_tlast = 1'b0;
        @(negedge clk);
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        m_tready = 1'b0;
        #1 chk("midrst lane2", 64'(m_tdata), 64'h0000_0000_0000_BBBB);
        sys_arstn = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        sys_arstn = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk("midrst idle", 64'(m_tvalid), 64'd0);
        push_beat(64'h0004_0003_0002_0001, 8'hFF, 1'b1);
        run(100, 100, 100, "after_rst");
        chk("after_rst out_count", 64'(outs), 64'd4);

`ifdef AXIS_DOWNSIZER_STATS_EN
        sys_arstn = 1'b0;
        @(negedge clk);
        sys_arstn = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++)
                push_beat({$urandom, $urandom}, (b == 3) ? 8'h03 : 8'hFF, (b == 3));
        run(100, 100, 500, "stats");
        chk("stats pkt_cnt", 64'(o_pkt_cnt), 64'd3);
        chk("stats beat_cnt", 64'(o_beat_cnt), 64'd39);
        chk("stats trim_cnt", 64'(o_trim_cnt), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
